// File: rtl/cpu_ram_banked.sv
// cpu_ram_banked
//   Multi-bank 32-bit scratch RAM on the CPU request/ack bus. There is one access
//   in flight at a time. Optional zero-clear after reset. Accesses to banks that
//   do not exist return err.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_CLEAR | zeroing word clr_cnt in every bank; requests parked in pending
//   ST_READY | serving accesses
//
// Ports
//   clk      system clock
//   reset_n  synchronous active-low reset
//   request  one-cycle access strobe; address/wdata/wmask qualify it
//   address  byte address, [1:0] ignored, bits above the bank field alias
//   wdata    write data
//   wmask    byte write enables, 4'b0000 = read
//   ack      one-cycle completion pulse
//   rdata    pre-access word, 0 when ack is low or on error
//   err      pulses with ack for an unpopulated bank
//   ready    high once the clear sequence has finished
module cpu_ram_banked #(
    parameter int NUM_BANKS    = 2,
    parameter int BANK_WORDS   = 4096,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        request,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        ready
);

    localparam int AW  = $clog2(BANK_WORDS);
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BWX = (BW > 0) ? BW : 1;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t          state, state_next;
    logic            ready_q;
    logic [AW-1:0]   clr_cnt;

    logic            pend_v;
    logic [31:0]     pend_addr, pend_wdata;
    logic [3:0]      pend_wmask;

    logic [31:0]     mem [NUM_BANKS][BANK_WORDS];

    logic [31:0]     acc_addr, acc_wdata;
    logic [3:0]      acc_wmask;
    logic [AW-1:0]   acc_word;
    logic [BWX-1:0]  acc_bank, bank_idx;
    logic            acc_err, accept, in_flight;

    logic            s1_v, s1_err, s2_v, s2_err;
    logic [31:0]     s1_data, s2_data;

    logic            unused_addr_bits;

    // A parked request always wins over a new one in the same cycle.
    always_comb begin
        acc_addr  = pend_v ? pend_addr  : address;
        acc_wdata = pend_v ? pend_wdata : wdata;
        acc_wmask = pend_v ? pend_wmask : wmask;
        acc_word  = acc_addr[2 +: AW];
        acc_bank  = (BW > 0) ? acc_addr[2+AW +: BWX] : '0;
        acc_err   = (32'(acc_bank) >= 32'(NUM_BANKS));
        bank_idx  = acc_err ? '0 : acc_bank;
    end

    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:2+AW+BW]};

    // With two-cycle latency the cycle after accept is busy; the ack cycle
    // itself is free, so back-to-back accesses are possible.
    assign in_flight = (READ_LATENCY == 2) ? s1_v : 1'b0;
    assign accept    = ready_q & (request | pend_v) & ~in_flight;

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_cnt == AW'(BANK_WORDS - 1)) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            ready_q    <= 1'b0;
            clr_cnt    <= '0;
            pend_v     <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            pend_wmask <= '0;
            s1_v       <= 1'b0;
            s1_err     <= 1'b0;
            s2_v       <= 1'b0;
            s2_err     <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == ST_READY);
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + AW'(1);
            if (accept && pend_v) begin
                pend_v <= 1'b0;
            end else if (!ready_q && request) begin
                pend_v     <= 1'b1;
                pend_addr  <= address;
                pend_wdata <= wdata;
                pend_wmask <= wmask;
            end
            s1_v   <= accept;
            s1_err <= acc_err;
            s2_v   <= s1_v;
            s2_err <= s1_err;
        end
    end

    // Array and data path carry no reset; the read captures the word before
    // any same-edge write (old-data semantics).
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            for (int b = 0; b < NUM_BANKS; b++) mem[b][clr_cnt] <= '0;
        end else if (accept && !acc_err) begin
            for (int i = 0; i < 4; i++)
                if (acc_wmask[i]) mem[bank_idx][acc_word][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
        if (accept) s1_data <= mem[bank_idx][acc_word];
        s2_data <= s1_data;
    end

    always_comb begin
        if (READ_LATENCY == 2) begin
            ack   = s2_v;
            err   = s2_v & s2_err;
            rdata = (s2_v && !s2_err) ? s2_data : '0;
        end else begin
            ack   = s1_v;
            err   = s1_v & s1_err;
            rdata = (s1_v && !s1_err) ? s1_data : '0;
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_cpu_ram_banked.sv
module tb_cpu_ram_banked;

    logic        clk;
    logic [2:0]  reset_n, request;
    logic [31:0] address, wdata;
    logic [3:0]  wmask;
    logic [2:0]  ack, err, ready;
    logic [31:0] rdata [3];

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: 3 banks x 16 words, latency 1, clear on reset
    cpu_ram_banked #(.NUM_BANKS(3), .BANK_WORDS(16), .READ_LATENCY(1), .CLEAR_ON_RST(1)) u_a (
        .clk(clk), .reset_n(reset_n[0]), .request(request[0]), .address(address),
        .wdata(wdata), .wmask(wmask), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .ready(ready[0]));

    // b: 2 banks x 4096 words, latency 1, clear on reset
    cpu_ram_banked #(.NUM_BANKS(2), .BANK_WORDS(4096), .READ_LATENCY(1), .CLEAR_ON_RST(1)) u_b (
        .clk(clk), .reset_n(reset_n[1]), .request(request[1]), .address(address),
        .wdata(wdata), .wmask(wmask), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .ready(ready[1]));

    // c: 3 banks x 4096 words, latency 2, no clear
    cpu_ram_banked #(.NUM_BANKS(3), .BANK_WORDS(4096), .READ_LATENCY(2), .CLEAR_ON_RST(0)) u_c (
        .clk(clk), .reset_n(reset_n[2]), .request(request[2]), .address(address),
        .wdata(wdata), .wmask(wmask), .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .ready(ready[2]));

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  wm;
        bit          chk;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic int lat_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, input bit chk, input logic [31:0] exp_rd,
                          input bit exp_err, input string name);
        int k;
        @(negedge clk);
        request[d] = 1'b1; address = a; wdata = wd; wmask = wm;
        @(negedge clk);
        request[d] = 1'b0;
        k = 1;
        while (!ack[d] && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, 32'(k), 32'(lat_of(d)));
        if (chk) check({name, " rdata"}, rdata[d], exp_rd);
        check({name, " err"}, 32'(err[d]), 32'(exp_err));
    endtask

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        int c;
        reset_n = 3'b000; request = 3'b000;
        address = '0; wdata = '0; wmask = '0;
        repeat (3) @(negedge clk);

        // reset values
        check("reset ready a", 32'(ready[0]), 32'd0);
        check("reset ready b", 32'(ready[1]), 32'd0);
        check("reset ready c", 32'(ready[2]), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset rdata", rdata[0], 32'd0);

        // clear takes exactly BANK_WORDS cycles
        reset_n = 3'b111;
        c = 0;
        while (!ready[0] && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("clear cycles", 32'(c), 32'd16);

        for (int b = 0; b < 3; b++)
            for (int w = 0; w < 16; w++)
                access(0, 32'(b*64 + w*4), 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "cleared word");

        c = 0;
        while (!ready[1] && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("b ready", 32'(ready[1]), 32'd1);

        // a: byte masks, decode errors, aliasing
        tbl.push_back('{0, 32'h10,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b0});
        tbl.push_back('{0, 32'h10,  32'hDEAD_BEEF, 4'h5, 1'b1, 32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{0, 32'h10,  32'h0,         4'h0, 1'b1, 32'hFFAD_FFEF, 1'b0});
        tbl.push_back('{0, 32'hC0,  32'h1234_5678, 4'hF, 1'b1, 32'h0,         1'b1});
        tbl.push_back('{0, 32'hC0,  32'h0,         4'h0, 1'b1, 32'h0,         1'b1});
        tbl.push_back('{0, 32'h00,  32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        tbl.push_back('{0, 32'h80,  32'h0,         4'h0, 1'b1, 32'h0,         1'b0});
        tbl.push_back('{0, 32'h110, 32'h0,         4'h0, 1'b1, 32'hFFAD_FFEF, 1'b0});
        tbl.push_back('{0, 32'h7C,  32'hA5A5_A5A5, 4'h8, 1'b1, 32'h0,         1'b0});
        tbl.push_back('{0, 32'h7C,  32'h0,         4'h0, 1'b1, 32'hA500_0000, 1'b0});
        // b: two banks of 4096, aliasing above the bank bit
        tbl.push_back('{1, 32'h0,    32'h11,   4'hF, 1'b1, 32'h0,  1'b0});
        tbl.push_back('{1, 32'h4000, 32'h22,   4'hF, 1'b1, 32'h0,  1'b0});
        tbl.push_back('{1, 32'h0,    32'h0,    4'h0, 1'b1, 32'h11, 1'b0});
        tbl.push_back('{1, 32'h4000, 32'h0,    4'h0, 1'b1, 32'h22, 1'b0});
        tbl.push_back('{1, 32'h8000, 32'h0,    4'h0, 1'b1, 32'h11, 1'b0});
        tbl.push_back('{1, 32'hC000, 32'h0,    4'h0, 1'b1, 32'h22, 1'b0});
        tbl.push_back('{1, 32'h7FFC, 32'hCAFE, 4'hF, 1'b1, 32'h0,  1'b0});
        tbl.push_back('{1, 32'h7FFC, 32'h0,    4'h0, 1'b1, 32'hCAFE, 1'b0});
        // c: uncleared RAM, latency 2, bank 3 unpopulated
        tbl.push_back('{2, 32'h0,     32'h33,        4'hF, 1'b0, 32'h0,         1'b0});
        tbl.push_back('{2, 32'h8000,  32'h44,        4'hF, 1'b0, 32'h0,         1'b0});
        tbl.push_back('{2, 32'h4,     32'h77,        4'hF, 1'b0, 32'h0,         1'b0});
        tbl.push_back('{2, 32'h8,     32'h0,         4'hF, 1'b0, 32'h0,         1'b0});
        tbl.push_back('{2, 32'hC000,  32'h99,        4'hF, 1'b1, 32'h0,         1'b1});
        tbl.push_back('{2, 32'h1C000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1});
        tbl.push_back('{2, 32'h0,     32'h0,         4'h0, 1'b1, 32'h33,        1'b0});
        tbl.push_back('{2, 32'h8000,  32'h0,         4'h0, 1'b1, 32'h44,        1'b0});
        tbl.push_back('{2, 32'h4000,  32'h5566_7788, 4'hF, 1'b0, 32'h0,         1'b0});
        tbl.push_back('{2, 32'h4000,  32'h0000_AA00, 4'h2, 1'b1, 32'h5566_7788, 1'b0});
        tbl.push_back('{2, 32'h4000,  32'h0,         4'h0, 1'b1, 32'h5566_AA88, 1'b0});

        foreach (tbl[i])
            access(tbl[i].d, tbl[i].addr, tbl[i].wd, tbl[i].wm, tbl[i].chk,
                   tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));

        // c: requests in consecutive ack cycles, with a dropped request in each busy cycle
        b2b_addr[0] = 32'h0;    b2b_exp[0] = 32'h33;
        b2b_addr[1] = 32'h8000; b2b_exp[1] = 32'h44;
        b2b_addr[2] = 32'h4000; b2b_exp[2] = 32'h5566_AA88;
        b2b_addr[3] = 32'h4;    b2b_exp[3] = 32'h77;
        @(negedge clk);
        request[2] = 1'b1; address = b2b_addr[0]; wdata = '0; wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b%0d busy ack", i), 32'(ack[2]), 32'd0);
            check($sformatf("b2b%0d busy rdata", i), rdata[2], 32'd0);
            request[2] = 1'b1; address = 32'h8; wdata = 32'hBAD0_BAD0; wmask = 4'hF;
            @(negedge clk);
            check($sformatf("b2b%0d ack", i), 32'(ack[2]), 32'd1);
            check($sformatf("b2b%0d rdata", i), rdata[2], b2b_exp[i]);
            if (i < 3) begin
                request[2] = 1'b1; address = b2b_addr[i+1]; wdata = '0; wmask = 4'h0;
            end else begin
                request[2] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b tail ack", 32'(ack[2]), 32'd0);
        check("b2b tail rdata", rdata[2], 32'd0);
        access(2, 32'h8, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "dropped write");

        // c: reset while in flight discards the ack
        @(negedge clk);
        request[2] = 1'b1; address = 32'h0; wmask = 4'h0;
        @(negedge clk);
        request[2] = 1'b0; reset_n[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("inflight reset ack", 32'(ack[2]), 32'd0);
        end
        check("inflight reset ready", 32'(ready[2]), 32'd0);
        reset_n[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post reset ack", 32'(ack[2]), 32'd0);
        end
        check("no-clear ready", 32'(ready[2]), 32'd1);
        access(2, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "after reset c");

        // a: request parked during clear, served on the first ready cycle
        @(negedge clk);
        reset_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n[0] = 1'b1;
        c = 0;
        while (!ready[0] && c < 40) begin
            if (c == 5) begin
                request[0] = 1'b1; address = 32'h14; wdata = 32'h5A5A_5A5A; wmask = 4'hF;
            end
            if (c == 6) request[0] = 1'b0;
            @(negedge clk);
            c++;
            check("pending early ack", 32'(ack[0]), 32'd0);
        end
        check("pending clear cycles", 32'(c), 32'd16);
        @(negedge clk);
        check("pending ack", 32'(ack[0]), 32'd1);
        check("pending rdata", rdata[0], 32'd0);
        check("pending err", 32'(err[0]), 32'd0);
        access(0, 32'h14, 32'h0, 4'h0, 1'b1, 32'h5A5A_5A5A, 1'b0, "pending write");
        access(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, "recleared");

        // a: reset in the middle of clear drops the parked request and restarts
        @(negedge clk);
        reset_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                request[0] = 1'b1; address = 32'h10; wmask = 4'h0;
            end
            if (i == 4) request[0] = 1'b0;
            @(negedge clk);
        end
        reset_n[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midclear reset ack", 32'(ack[0]), 32'd0);
        end
        reset_n[0] = 1'b1;
        c = 0;
        while (!ready[0] && c < 40) begin
            @(negedge clk);
            c++;
            check("restart ack", 32'(ack[0]), 32'd0);
        end
        check("restart clear cycles", 32'(c), 32'd16);
        repeat (4) begin
            @(negedge clk);
            check("discarded pending ack", 32'(ack[0]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
